expr_scan_ctrl: RTL and testbench

//   Sequencer for the single-character expression recogniser (digit (op digit)*, op = any non-digit).
//   On start, reads a string of len bytes from a byte memory at base and streams it into the

---
 rtl/expr_scan_ctrl_if.sv | 30 +++
 rtl/expr_scan_ctrl.sv | 163 ++++++++++++++++
 tb/tb_expr_scan_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/expr_scan_ctrl_if.sv
// Bundle of the scan request/status, byte-memory read and recogniser signals
// shared between the scan sequencer and its environment.
interface expr_scan_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] len;
    logic              busy;
    logic              done;
    logic              match;
    logic [7:0]        match_cnt;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              chk_clr;
    logic [7:0]        chk_in;
    logic              chk_out;

    modport master (
        output start, abort, base, len, mem_data, chk_out,
        input  busy, done, match, match_cnt, mem_rd, mem_addr, chk_clr, chk_in
    );

    modport slave (
        input  start, abort, base, len, mem_data, chk_out,
        output busy, done, match, match_cnt, mem_rd, mem_addr, chk_clr, chk_in
    );
endinterface

// File: rtl/expr_scan_ctrl.sv
// Scan sequencer for the single-character expression recogniser.
// Reads len bytes starting at base (one per cycle), streams them into the
// recogniser, then samples its verdict and pulses done with match valid.
// The recogniser has no enable, so it is held in reset (chk_clr) whenever
// no valid character is being presented on chk_in.
//
// state  | meaning
// IDLE   | waiting for start
// READ   | issuing one memory read per cycle, len cycles in total
// DRAIN  | two cycles letting the last reads flow through to the recogniser
// SAMPLE | recogniser output reflects the whole string; captured at cycle end
// DONE   | done pulse cycle; behaves like IDLE for a new start
module expr_scan_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic           clk,
    input  logic           clr,
    expr_scan_ctrl_if.slave bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_READ   = 3'd1;
    localparam logic [2:0] S_DRAIN  = 3'd2;
    localparam logic [2:0] S_SAMPLE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]        state_q,    state_d;
    logic [ADDR_W-1:0] rem_q,      rem_d;
    logic              drain_q,    drain_d;
    logic              len_zero_q, len_zero_d;
    logic              rd_dly_q,   rd_dly_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic              match_q,    match_d;
    logic [7:0]        cnt_q,      cnt_d;
    logic              mem_rd_q,   mem_rd_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              chk_clr_q,  chk_clr_d;
    logic [7:0]        chk_in_q,   chk_in_d;
    logic              verdict;

    // Next-state and next-output computation; abort overrides every busy state.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        drain_d    = drain_q;
        len_zero_d = len_zero_q;
        rd_dly_d   = mem_rd_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        match_d    = match_q;
        cnt_d      = cnt_q;
        mem_rd_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        chk_clr_d  = 1'b1;
        chk_in_d   = bus.mem_data;
        verdict    = ~len_zero_q & bus.chk_out;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                if (bus.start) begin
                    busy_d     = 1'b1;
                    len_zero_d = (bus.len == '0);
                    if (bus.len == '0) begin
                        // Empty string: skip straight to the verdict, which is forced to 0.
                        state_d = S_SAMPLE;
                    end else begin
                        state_d    = S_READ;
                        mem_rd_d   = 1'b1;
                        mem_addr_d = bus.base;
                        rem_d      = bus.len - 1'b1;
                    end
                end
            end
            S_READ: begin
                // A read issued two cycles before the next one means a valid char then.
                chk_clr_d = ~rd_dly_q;
                if (rem_q != '0) begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = mem_addr_q + 1'b1;
                    rem_d      = rem_q - 1'b1;
                end else begin
                    state_d = S_DRAIN;
                    drain_d = 1'b0;
                end
            end
            S_DRAIN: begin
                chk_clr_d = 1'b0;
                if (drain_q) begin
                    state_d = S_SAMPLE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            S_SAMPLE: begin
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                match_d = verdict;
                if (verdict && (cnt_q != 8'hFF)) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (bus.abort && busy_q) begin
            state_d   = S_IDLE;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            mem_rd_d  = 1'b0;
            chk_clr_d = 1'b1;
            match_d   = match_q;
            cnt_d     = cnt_q;
        end
    end

    // State and registered outputs; clr forces everything to its idle value at once.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= S_IDLE;
            rem_q      <= '0;
            drain_q    <= 1'b0;
            len_zero_q <= 1'b0;
            rd_dly_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            match_q    <= 1'b0;
            cnt_q      <= 8'd0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            chk_clr_q  <= 1'b1;
            chk_in_q   <= 8'd0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            drain_q    <= drain_d;
            len_zero_q <= len_zero_d;
            rd_dly_q   <= rd_dly_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            match_q    <= match_d;
            cnt_q      <= cnt_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            chk_clr_q  <= chk_clr_d;
            chk_in_q   <= chk_in_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.match     = match_q;
    assign bus.match_cnt = cnt_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.chk_clr   = chk_clr_q;
    assign bus.chk_in    = chk_in_q;
endmodule

// File: tb/tb_expr_scan_ctrl.sv
// Directed bench for expr_scan_ctrl: byte memory with one-cycle read latency
// and a reference expression recogniser, both modelled here.
module tb_expr_scan_ctrl;
    logic clk = 1'b0;
    logic clr = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    logic [7:0] mem [256];
    logic [1:0] rs;

    expr_scan_ctrl_if #(.ADDR_W(8)) bus ();

    expr_scan_ctrl #(.ADDR_W(8)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Byte memory: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];
    end

    // Recogniser for digit (op digit)*: 0 = expect digit, 1 = accepted, 2 = error.
    always @(posedge clk or posedge bus.chk_clr) begin
        if (bus.chk_clr) rs <= 2'd0;
        else begin
            case (rs)
                2'd0:    rs <= (bus.chk_in >= "0" && bus.chk_in <= "9") ? 2'd1 : 2'd2;
                2'd1:    rs <= (bus.chk_in >= "0" && bus.chk_in <= "9") ? 2'd2 : 2'd0;
                default: rs <= 2'd2;
            endcase
        end
    end
    assign bus.chk_out = (rs == 2'd1);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] a, input string s);
        for (int i = 0; i < s.len(); i++) mem[8'(a + 8'(i))] = s[i];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a scan in the current cycle (cycle 0) and checks every cycle up to
    // and including the done cycle. Returns sitting in the done cycle.
    task automatic run_scan(input logic [7:0] b, input int n, input logic exp_m,
                            input logic [7:0] exp_cnt);
        int         last;
        logic [7:0] ea;
        last = (n == 0) ? 2 : n + 4;
        bus.start = 1'b1;
        bus.base  = b;
        bus.len   = 8'(n);
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= last; c++) begin
            ea = b + 8'(c - 1);
            check("busy", 32'(bus.busy), 32'(c < last));
            check("mem_rd", 32'(bus.mem_rd), 32'(n > 0 && c <= n));
            if (n > 0 && c <= n) check("mem_addr", 32'(bus.mem_addr), 32'(ea));
            check("chk_clr", 32'(bus.chk_clr), 32'(!(n > 0 && c >= 3 && c <= n + 3)));
            check("done", 32'(bus.done), 32'(c == last));
            if (c == last) begin
                check("match", 32'(bus.match), 32'(exp_m));
                check("match_cnt", 32'(bus.match_cnt), 32'(exp_cnt));
            end else begin
                tick();
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},   32'(bus.busy), 32'd0);
        check({tag, "_done"},   32'(bus.done), 32'd0);
        check({tag, "_match"},  32'(bus.match), 32'd0);
        check({tag, "_cnt"},    32'(bus.match_cnt), 32'd0);
        check({tag, "_mem_rd"}, 32'(bus.mem_rd), 32'd0);
        check({tag, "_addr"},   32'(bus.mem_addr), 32'd0);
        check({tag, "_chk_in"}, 32'(bus.chk_in), 32'd0);
        check({tag, "_chk_clr"}, 32'(bus.chk_clr), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.base  = 8'h00;
        bus.len   = 8'h00;
        bus.mem_data = 8'h00;

        // Reset values
        tick();
        tick();
        check_reset_outputs("rst");
        clr = 1'b0;
        tick();

        // T1: "1+2" at 0x10
        load(8'h10, "1+2");
        run_scan(8'h10, 3, 1'b1, 8'd1);

        // T2: started in the previous done cycle
        load(8'h40, "12");
        run_scan(8'h40, 2, 1'b0, 8'd1);
        load(8'h50, "9-8/");
        run_scan(8'h50, 4, 1'b0, 8'd1);

        // T3: empty string
        run_scan(8'h60, 0, 1'b0, 8'd1);
        tick();
        check("match_held", 32'(bus.match), 32'd0);
        check("done_pulse", 32'(bus.done), 32'd0);

        // T4: address wrap
        load(8'hFE, "3*4");
        run_scan(8'hFE, 3, 1'b1, 8'd2);
        tick();

        // T5: abort in cycle 3, ignored start in cycle 2
        load(8'h20, "1+2+3");
        bus.start = 1'b1; bus.base = 8'h20; bus.len = 8'd5;
        tick();                          // cycle 1
        bus.start = 1'b0;
        tick();                          // cycle 2
        bus.start = 1'b1; bus.base = 8'h80; bus.len = 8'd1;
        check("t5_busy_c2", 32'(bus.busy), 32'd1);
        tick();                          // cycle 3
        bus.start = 1'b0;
        bus.abort = 1'b1;
        tick();                          // cycle 4
        bus.abort = 1'b0;
        check("t5_busy", 32'(bus.busy), 32'd0);
        check("t5_mem_rd", 32'(bus.mem_rd), 32'd0);
        check("t5_chk_clr", 32'(bus.chk_clr), 32'd1);
        for (int i = 0; i < 6; i++) begin
            check("t5_no_done", 32'(bus.done), 32'd0);
            check("t5_idle_rd", 32'(bus.mem_rd), 32'd0);
            tick();
        end
        check("t5_cnt_kept", 32'(bus.match_cnt), 32'd2);
        load(8'h30, "7");
        run_scan(8'h30, 1, 1'b1, 8'd3);
        tick();

        // T6: clr mid-scan, cycle 4 of a len=6 scan
        load(8'h70, "1+2+3+");
        bus.start = 1'b1; bus.base = 8'h70; bus.len = 8'd6;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();                          // cycle 4
        check("t6_rd_before", 32'(bus.mem_rd), 32'd1);
        clr = 1'b1;
        #1;
        check_reset_outputs("t6");
        tick();
        clr = 1'b0;
        tick();

        // Saturation: 256 matching scans back to back
        load(8'h90, "5");
        for (int k = 0; k < 256; k++) begin
            bus.start = 1'b1; bus.base = 8'h90; bus.len = 8'd1;
            tick();
            bus.start = 1'b0;
            for (int w = 0; w < 10 && !bus.done; w++) tick();
            if (k == 0) check("sat_first", 32'(bus.match_cnt), 32'd1);
            if (k == 254) check("sat_255", 32'(bus.match_cnt), 32'd255);
        end
        check("sat_done", 32'(bus.done), 32'd1);
        check("sat_hold", 32'(bus.match_cnt), 32'd255);
        check("sat_match", 32'(bus.match), 32'd1);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
